// File: rtl/pipemdu_if.sv
// rtl/pipemdu_if.sv - EX-stage multiply/divide unit bus between pipeline and MDU
interface pipemdu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic [3:0]       emdop;
  logic             ecancel;
  logic [WIDTH-1:0] emdres;
  logic             emdbusy;
  logic             emdstall;
  logic [WIDTH-1:0] ehi;
  logic [WIDTH-1:0] elo;

  // Pipeline side: presents the D/E operands and op, consumes results and stall
  modport master (
    output ea, eb, emdop, ecancel,
    input  emdres, emdbusy, emdstall, ehi, elo
  );

  // MDU side
  modport slave (
    input  ea, eb, emdop, ecancel,
    output emdres, emdbusy, emdstall, ehi, elo
  );
endinterface

// File: rtl/pipemdu.sv
// rtl/pipemdu.sv - multi-cycle shift-add multiply / restoring divide unit owning HI/LO
module pipemdu #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipemdu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  // acc: product upper half / partial remainder; low: multiplier+product lower half / quotient
  logic [WIDTH-1:0] acc, low;
  // dvs: multiplicand / divisor magnitude; araw: raw dividend kept for divide-by-zero
  logic [WIDTH-1:0] dvs, araw;
  logic             neg, rneg, dz, is_div;

  logic [3:0]         op;
  logic               is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic               div_neg;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Operand conditioning and one-bit-per-cycle datapath
  always_comb begin
    op        = bus.ecancel ? OP_NONE : bus.emdop;
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_mag     = (is_signed && bus.ea[WIDTH-1]) ? -bus.ea : bus.ea;
    b_mag     = (is_signed && bus.eb[WIDTH-1]) ? -bus.eb : bus.eb;
    mul_sum   = {1'b0, acc} + {1'b0, (low[0] ? dvs : {WIDTH{1'b0}})};
    div_diff  = {1'b0, acc, low[WIDTH-1]} - {2'b00, dvs};
    // bit WIDTH is always clear on a successful subtract, so OR-ing it in is harmless
    div_neg   = div_diff[WIDTH+1] | div_diff[WIDTH];
    prod      = {acc, low};
    prod_fix  = neg ? -prod : prod;
    q_fix     = neg ? -low : low;
    r_fix     = rneg ? -acc : acc;
  end

  // Sequencer: accept in IDLE, iterate WIDTH cycles, sign-fix, commit HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      low    <= '0;
      dvs    <= '0;
      araw   <= '0;
      neg    <= 1'b0;
      rneg   <= 1'b0;
      dz     <= 1'b0;
      is_div <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) begin
            is_div <= (op == OP_DIV) || (op == OP_DIVU);
            neg    <= is_signed & (bus.ea[WIDTH-1] ^ bus.eb[WIDTH-1]);
            rneg   <= is_signed & bus.ea[WIDTH-1];
            dz     <= (bus.eb == '0);
            araw   <= bus.ea;
            dvs    <= (op == OP_MULT || op == OP_MULTU) ? a_mag : b_mag;
            // multiply keeps the multiplier in low; divide shifts the dividend out of low
            low    <= (op == OP_MULT || op == OP_MULTU) ? b_mag : a_mag;
            acc    <= '0;
            state  <= (op == OP_MULT || op == OP_MULTU) ? MUL : DIV;
          end else if (op == OP_MTHI) begin
            hi <= bus.ea;
          end else if (op == OP_MTLO) begin
            lo <= bus.ea;
          end
        end
        MUL: begin
          acc <= mul_sum[WIDTH:1];
          low <= {mul_sum[0], low[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        DIV: begin
          if (!div_neg) begin
            acc <= div_diff[WIDTH-1:0];
            low <= {low[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {acc[WIDTH-2:0], low[WIDTH-1]};
            low <= {low[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (dz) begin
            lo <= {WIDTH{1'b1}};
            hi <= araw;
          end else begin
            lo <= q_fix;
            hi <= r_fix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status and result mux back to EX
  always_comb begin
    bus.emdbusy  = (state != IDLE);
    bus.emdstall = bus.emdbusy && (op >= OP_MULT) && (op <= OP_MTLO);
    bus.ehi      = hi;
    bus.elo      = lo;
    if (op == OP_MFHI)      bus.emdres = hi;
    else if (op == OP_MFLO) bus.emdres = lo;
    else                    bus.emdres = '0;
  end

endmodule

// File: tb/tb_pipemdu.sv
// tb/tb_pipemdu.sv - directed self-checking bench for pipemdu
module tb_pipemdu;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5;
  localparam logic [3:0] MFLO  = 4'd6;
  localparam logic [3:0] MTHI  = 4'd7;
  localparam logic [3:0] MTLO  = 4'd8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n;

  pipemdu_if #(.WIDTH(32)) mif ();

  pipemdu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present an op for exactly one edge, then return to NONE
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.emdop   = op;
    mif.ea      = a;
    mif.eb      = b;
    mif.ecancel = 1'b0;
    step();
    mif.emdop   = NONE;
  endtask

  // count post-edge samples with emdbusy high (bounded)
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (mif.emdbusy && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp);
    int c;
    issue(op, a, b);
    wait_idle(c);
    check({tag, "_lat"}, 64'(c), 64'd33);
    check(tag, {mif.ehi, mif.elo}, exp);
  endtask

  initial begin
    rst = 1'b1;
    mif.emdop = NONE;
    mif.ea = '0;
    mif.eb = '0;
    mif.ecancel = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy",  64'(mif.emdbusy),  64'd0);
    check("rst_stall", 64'(mif.emdstall), 64'd0);
    check("rst_hilo",  {mif.ehi, mif.elo}, 64'd0);
    check("rst_res",   64'(mif.emdres),   64'd0);

    // MT then MF back-to-back; cancelled MTLO leaves LO alone
    issue(MTHI, 32'hA5A5_0000, 32'h0);
    mif.emdop = MFHI;
    #1;
    check("mthi_mfhi", 64'(mif.emdres), 64'h0000_0000_A5A5_0000);
    step();
    issue(MTLO, 32'h2222_3333, 32'h0);
    mif.emdop = MTLO; mif.ea = 32'hDEAD_BEEF; mif.ecancel = 1'b1;
    step();
    mif.emdop = NONE; mif.ecancel = 1'b0;
    check("mtlo_cancel", {mif.ehi, mif.elo}, 64'hA5A5_0000_2222_3333);

    // reset in the middle of a multiply (cnt=10)
    issue(MULT, 32'd5, 32'd6);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 64'(mif.emdbusy), 64'd0);
    check("midrst_hilo", {mif.ehi, mif.elo}, 64'd0);
    mif.emdop = MFLO;
    #1;
    check("midrst_mflo", 64'(mif.emdres), 64'd0);
    step();
    mif.emdop = NONE;
    step();
    check("midrst_idle", 64'(mif.emdbusy), 64'd0);

    // multiply
    run("mult_neg",  MULT,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    run("multu_big", MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA);
    run("mult_nn",   MULT,  32'hFFFF_FFFD, 32'hFFFF_FFF9, 64'h0000_0000_0000_0015);

    // divide
    run("div_neg",   DIV,  32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run("divu_7_2",  DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
    run("div_7_m2",  DIV,  32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    run("divu_dz",   DIVU, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
    run("div_dz",    DIV,  32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
    run("div_ovf",   DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    // MFLO held behind a multiply stalls until IDLE
    issue(MULT, 32'd5, 32'd6);
    mif.emdop = MFLO;
    #1;
    n = 0;
    while (mif.emdstall && n < 200) begin
      n++;
      step();
    end
    check("stall_len",   64'(n), 64'd33);
    check("stall_clear", 64'(mif.emdstall), 64'd0);
    check("stall_mflo",  64'(mif.emdres), 64'd30);
    step();
    mif.emdop = NONE;

    // cancelled op while busy does not stall; DIV behind MULT keeps old HI/LO until its FIX
    issue(MULT, 32'd7, 32'd9);
    mif.emdop = MFLO; mif.ecancel = 1'b1;
    #1;
    check("cancel_stall", 64'(mif.emdstall), 64'd0);
    check("cancel_busy",  64'(mif.emdbusy),  64'd1);
    mif.ecancel = 1'b0; mif.emdop = DIV; mif.ea = 32'd100; mif.eb = 32'd7;
    #1;
    check("b2b_stall", 64'(mif.emdstall), 64'd1);
    n = 0;
    while (mif.emdbusy && n < 200) begin
      n++;
      step();
    end
    check("b2b_mult", {mif.ehi, mif.elo}, 64'd63);
    step();
    mif.emdop = NONE;
    for (int i = 0; i < 20; i++) step();
    check("b2b_hold", {mif.ehi, mif.elo}, 64'd63);
    wait_idle(n);
    check("b2b_div", {mif.ehi, mif.elo}, 64'h0000_0002_0000_000E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
